// File: rtl/sdram_port_arbiter.sv
// Two-port slot arbiter in front of a 14-phase SDRAM controller.
// Port 0 (CPU) and port 1 (DMA/video) share one access per slot, alternating on contention.
module sdram_port_arbiter #(
    parameter int DATA_PHASE = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clkref,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic [22:0] p0_addr,
    input  logic [22:0] p1_addr,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic [7:0]  p0_din,
    input  logic [7:0]  p1_din,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic [7:0]  p0_dout,
    output logic [7:0]  p1_dout,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic [7:0]  mem_dout
);
    localparam int         NUM_PORTS = 2;
    localparam logic [3:0] PH_LAST   = 4'd13;
    localparam logic [3:0] PH_DATA   = 4'(DATA_PHASE);

    logic [NUM_PORTS-1:0]       req, we, ack, hit;
    logic [NUM_PORTS-1:0][22:0] addr;
    logic [NUM_PORTS-1:0][7:0]  din, dout;
    logic [3:0]                 phase;
    logic                       busy, owner, last_grant;
    logic                       arb_edge, done_edge, grant_any, grant_sel;

    assign req  = {p1_req, p0_req};
    assign we   = {p1_we, p0_we};
    assign addr = {p1_addr, p0_addr};
    assign din  = {p1_din, p0_din};

    assign p0_ack  = ack[0];
    assign p1_ack  = ack[1];
    assign p0_dout = dout[0];
    assign p1_dout = dout[1];

    // Last cycle before the controller issues ACTIVE.
    assign arb_edge  = (phase == PH_LAST) && !clkref;
    assign done_edge = busy && (phase == PH_DATA);
    assign grant_any = |req;
    // On a tie, the port that did not win last time; otherwise the lone requester.
    assign grant_sel = (&req) ? ~last_grant : req[1];
    assign hit       = done_edge ? (NUM_PORTS'(1) << owner) : '0;

    // Phase counter tracks the controller's q: stalls at 13 and 0 on clkref.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
        end else if (phase == PH_LAST) begin
            if (!clkref) phase <= '0;
        end else if (phase == 4'd0) begin
            if (clkref) phase <= 4'd1;
        end else begin
            phase <= phase + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
        end else if (arb_edge) begin
            busy <= grant_any;
            if (grant_any) begin
                owner      <= grant_sel;
                last_grant <= grant_sel;
                mem_addr   <= addr[grant_sel];
                mem_din    <= din[grant_sel];
                mem_we     <= we[grant_sel];
            end else begin
                // Idle slot: harmless read of the last address.
                mem_we <= 1'b0;
            end
        end else if (done_edge) begin
            busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack  <= '0;
            dout <= '0;
        end else begin
            ack <= hit;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (hit[i] && !mem_we) dout[i] <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected acks queued at request time,
// compared against acks observed by a negedge monitor.
module tb_sdram_port_arbiter;
    localparam int DP = 7;

    typedef struct packed {
        logic        port;
        logic        two;
        logic [3:0]  ph;
        logic [22:0] addr;
        logic        we;
        logic [7:0]  din;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [15:0] slot;
        logic [15:0] cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clkref;
    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic [22:0] p0_addr = '0, p1_addr = '0;
    logic        p0_we = 1'b0, p1_we = 1'b0;
    logic [7:0]  p0_din = '0, p1_din = '0;
    logic        p0_ack, p1_ack;
    logic [7:0]  p0_dout, p1_dout;
    logic [22:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_dout;

    logic [3:0]  mph;
    logic [15:0] slot_no;
    logic [15:0] cyc = '0;
    logic        stall_en = 1'b0;
    rec_t        exp_q[$], obs_q[$];
    rec_t        mon_r, e_r, o_r;
    bit          to_r;
    logic [7:0]  ed0, ed1;
    int          checks = 0, errors = 0;

    function automatic logic [7:0] mdl(input logic [22:0] a);
        return (a == 23'h000123) ? 8'h5A : (a[7:0] ^ 8'h3C);
    endfunction

    assign mem_dout = mdl(mem_addr);
    assign clkref   = (mph != 4'd13) || stall_en;

    sdram_port_arbiter #(.DATA_PHASE(DP)) dut (
        .clk(clk), .reset_n(reset_n), .clkref(clkref),
        .p0_req(p0_req), .p1_req(p1_req), .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_we(p0_we), .p1_we(p1_we), .p0_din(p0_din), .p1_din(p1_din),
        .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_dout(p0_dout), .p1_dout(p1_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 16'd1;

    // Reference slot phase, stepped by the controller's rule.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mph     <= '0;
            slot_no <= '0;
        end else if (mph == 4'd13) begin
            if (!clkref) begin
                mph     <= '0;
                slot_no <= slot_no + 16'd1;
            end
        end else if (mph == 4'd0) begin
            if (clkref) mph <= 4'd1;
        end else begin
            mph <= mph + 4'd1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && (p0_ack || p1_ack)) begin
            mon_r      = '0;
            mon_r.port = p1_ack;
            mon_r.two  = p0_ack && p1_ack;
            mon_r.ph   = mph;
            mon_r.addr = mem_addr;
            mon_r.we   = mem_we;
            mon_r.din  = mem_din;
            mon_r.d0   = p0_dout;
            mon_r.d1   = p1_dout;
            mon_r.slot = slot_no;
            mon_r.cyc  = cyc;
            obs_q.push_back(mon_r);
        end
    end

    task automatic drive(input logic port, input logic r, input logic [22:0] a,
                         input logic w, input logic [7:0] d);
        if (port) begin
            p1_req = r; p1_addr = a; p1_we = w; p1_din = d;
        end else begin
            p0_req = r; p0_addr = a; p0_we = w; p0_din = d;
        end
    endtask

    task automatic expect_txn(input logic port, input logic [22:0] a, input logic w,
                              input logic [7:0] d);
        rec_t e;
        e = '0;
        if (!w) begin
            if (port) ed1 = mdl(a);
            else      ed0 = mdl(a);
        end
        e.port = port;
        e.ph   = 4'(DP + 1);
        e.addr = a;
        e.we   = w;
        e.din  = d;
        e.d0   = ed0;
        e.d1   = ed1;
        exp_q.push_back(e);
    endtask

    task automatic get_pair(output rec_t e, output rec_t o, output bit to);
        to = 1'b1;
        e  = '0;
        o  = '0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #2;
            if (obs_q.size() > 0) begin
                to = 1'b0;
                break;
            end
        end
        if (!to) o = obs_q.pop_front();
        if (exp_q.size() > 0) e = exp_q.pop_front();
    endtask

    task automatic wait_ph(input logic [3:0] p);
        int n;
        n = 0;
        @(negedge clk);
        while (mph !== p && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (mph !== p) begin
            errors++;
            $display("FAIL wait_phase got=%0d want=%0d", mph, p);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_addr, mem_din, mem_we} !== 32'h0) begin
            errors++; $display("FAIL reset_mem got=%h/%h/%b want=0", mem_addr, mem_din, mem_we);
        end
        checks++;
        if ({p0_ack, p1_ack} !== 2'b00) begin
            errors++; $display("FAIL reset_ack got=%b%b want=00", p0_ack, p1_ack);
        end
        checks++;
        if ({p0_dout, p1_dout} !== 16'h0) begin
            errors++; $display("FAIL reset_dout got=%h/%h want=0", p0_dout, p1_dout);
        end
        ed0 = '0;
        ed1 = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        wait_ph(4'd2);
        drive(1'b0, 1'b1, 23'h000123, 1'b0, 8'h00);
        expect_txn(1'b0, 23'h000123, 1'b0, 8'h00);
        get_pair(e_r, o_r, to_r);
        drive(1'b0, 1'b0, 23'h000123, 1'b0, 8'h00);
        checks++;
        if (to_r || o_r.port !== e_r.port || o_r.two) begin
            errors++; $display("FAIL rd_port got=%b two=%b timeout=%b want=%b", o_r.port, o_r.two, to_r, e_r.port);
        end
        checks++;
        if (o_r.ph !== e_r.ph) begin
            errors++; $display("FAIL rd_ack_phase got=%0d want=%0d", o_r.ph, e_r.ph);
        end
        checks++;
        if (o_r.addr !== e_r.addr || o_r.we !== 1'b0) begin
            errors++; $display("FAIL rd_mem_addr got=%h we=%b want=%h we=0", o_r.addr, o_r.we, e_r.addr);
        end
        checks++;
        if (o_r.d0 !== e_r.d0 || o_r.d1 !== e_r.d1) begin
            errors++; $display("FAIL rd_dout got=%h/%h want=%h/%h", o_r.d0, o_r.d1, e_r.d0, e_r.d1);
        end
        wait_ph(4'd12);
        wait_ph(4'd10);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL rd_extra_ack got=%0d want=0", obs_q.size());
        end
    endtask

    task automatic test_single_write();
        bit bad;
        wait_ph(4'd2);
        drive(1'b1, 1'b1, 23'h7FFFFF, 1'b1, 8'hC3);
        expect_txn(1'b1, 23'h7FFFFF, 1'b1, 8'hC3);
        wait_ph(4'd0);
        bad = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (mem_we !== 1'b1 || mem_din !== 8'hC3 || mem_addr !== 23'h7FFFFF) bad = 1'b1;
            if (mph == 4'd9) p1_req = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL wr_mem_hold got=%h/%h/%b want=7fffff/c3/1", mem_addr, mem_din, mem_we);
        end
        get_pair(e_r, o_r, to_r);
        checks++;
        if (to_r || o_r.port !== e_r.port || o_r.two || o_r.ph !== e_r.ph) begin
            errors++; $display("FAIL wr_ack got=%b ph=%0d timeout=%b want=%b ph=%0d", o_r.port, o_r.ph, to_r, e_r.port, e_r.ph);
        end
        checks++;
        if (o_r.d0 !== e_r.d0 || o_r.d1 !== e_r.d1) begin
            errors++; $display("FAIL wr_dout got=%h/%h want=%h/%h", o_r.d0, o_r.d1, e_r.d0, e_r.d1);
        end
    endtask

    task automatic test_idle();
        wait_ph(4'd1);
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 23'h7FFFFF || mem_din !== 8'hC3) begin
            errors++; $display("FAIL idle_mem got=%h/%h/%b want=7fffff/c3/0", mem_addr, mem_din, mem_we);
        end
        wait_ph(4'd12);
        wait_ph(4'd10);
        checks++;
        if (obs_q.size() != 0 || p0_dout !== ed0 || p1_dout !== ed1) begin
            errors++; $display("FAIL idle_quiet got=%0d acks %h/%h want=0 acks %h/%h", obs_q.size(), p0_dout, p1_dout, ed0, ed1);
        end
    endtask

    task automatic test_contention();
        logic [15:0] prev_slot;
        prev_slot = '0;
        wait_ph(4'd3);
        drive(1'b0, 1'b1, 23'h000200, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 23'h000301, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) expect_txn(k[0], k[0] ? 23'h000301 : 23'h000200, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            get_pair(e_r, o_r, to_r);
            checks++;
            if (to_r || o_r.port !== e_r.port || o_r.two || o_r.ph !== e_r.ph) begin
                errors++; $display("FAIL cont_grant%0d got=%b two=%b ph=%0d want=%b ph=%0d", k, o_r.port, o_r.two, o_r.ph, e_r.port, e_r.ph);
            end
            checks++;
            if (o_r.d0 !== e_r.d0 || o_r.d1 !== e_r.d1 || (k > 0 && o_r.slot !== prev_slot + 16'd1)) begin
                errors++; $display("FAIL cont_slot%0d got=%h/%h slot=%0d want=%h/%h slot=%0d", k, o_r.d0, o_r.d1, o_r.slot, e_r.d0, e_r.d1, prev_slot + 16'd1);
            end
            prev_slot = o_r.slot;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        wait_ph(4'd12);
        wait_ph(4'd10);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL cont_extra_ack got=%0d want=0", obs_q.size());
        end
    endtask

    task automatic test_stall();
        logic [22:0] sa;
        logic [7:0]  sd;
        logic        sw;
        logic [15:0] c0;
        bit          bad;
        wait_ph(4'd12);
        sa = mem_addr; sd = mem_din; sw = mem_we;
        stall_en = 1'b1;
        drive(1'b0, 1'b1, 23'h0ABCDE, 1'b1, 8'h11);
        expect_txn(1'b0, 23'h0ABCDE, 1'b1, 8'h11);
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_addr !== sa || mem_din !== sd || mem_we !== sw) bad = 1'b1;
            if (p0_ack || p1_ack) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL stall_hold got=%h/%h/%b want=%h/%h/%b", mem_addr, mem_din, mem_we, sa, sd, sw);
        end
        c0 = cyc;
        stall_en = 1'b0;
        get_pair(e_r, o_r, to_r);
        p0_req = 1'b0;
        checks++;
        if (to_r || o_r.port !== e_r.port || o_r.addr !== e_r.addr || o_r.we !== e_r.we || o_r.din !== e_r.din) begin
            errors++; $display("FAIL stall_txn got=%b %h/%b/%h want=%b %h/%b/%h", o_r.port, o_r.addr, o_r.we, o_r.din, e_r.port, e_r.addr, e_r.we, e_r.din);
        end
        checks++;
        if (o_r.cyc !== c0 + 16'(DP + 2) || o_r.ph !== e_r.ph) begin
            errors++; $display("FAIL stall_latency got=%0d ph=%0d want=%0d ph=%0d", o_r.cyc - c0, o_r.ph, DP + 2, e_r.ph);
        end
    endtask

    task automatic test_reset_mid();
        wait_ph(4'd10);
        drive(1'b0, 1'b1, 23'h000055, 1'b0, 8'h00);
        wait_ph(4'd4);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_din, mem_we, p0_ack, p1_ack, p0_dout, p1_dout} !== 50'h0) begin
            errors++; $display("FAIL rstmid_outputs got=%h/%h/%b %b%b %h/%h want=0", mem_addr, mem_din, mem_we, p0_ack, p1_ack, p0_dout, p1_dout);
        end
        p0_req = 1'b0;
        ed0 = '0;
        ed1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ph(4'd12);
        wait_ph(4'd10);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL rstmid_stale_ack got=%0d want=0", obs_q.size());
        end
        drive(1'b1, 1'b1, 23'h000123, 1'b0, 8'h00);
        expect_txn(1'b1, 23'h000123, 1'b0, 8'h00);
        get_pair(e_r, o_r, to_r);
        p1_req = 1'b0;
        checks++;
        if (to_r || o_r.port !== e_r.port || o_r.ph !== e_r.ph || o_r.d0 !== e_r.d0 || o_r.d1 !== e_r.d1) begin
            errors++; $display("FAIL rstmid_next got=%b ph=%0d %h/%h want=%b ph=%0d %h/%h", o_r.port, o_r.ph, o_r.d0, o_r.d1, e_r.port, e_r.ph, e_r.d0, e_r.d1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_idle();
        test_contention();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
